t48_int_ctrl: RTL

//  Consumer side of the T48 timer/counter: turns timer overflow and external /INT into
//  the timer flag (TF), a timer-interrupt pending latch and the interrupt request the

---
 rtl/t48_int_ctrl_pkg.sv | 15 +
 rtl/t48_int_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/t48_int_ctrl_pkg.sv
// T48 interrupt controller shared definitions:
// machine-state codes, default vectors, FSM states.
package t48_pack;

  localparam logic [2:0] MSTATE4     = 3'b100;
  localparam logic [7:0] EXT_VEC_DEF = 8'h03;
  localparam logic [7:0] TIM_VEC_DEF = 8'h07;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ISR  = 2'd2
  } int_state_t;

endpackage

// File: rtl/t48_int_ctrl.sv
// T48 interrupt controller: TF, timer pending, /INT sampling
// and the CALL-injection request/in-service sequencing.
module t48_int_ctrl
  import t48_pack::*;
#(
  parameter logic [7:0] EXT_VEC = EXT_VEC_DEF,
  parameter logic [7:0] TIM_VEC = TIM_VEC_DEF
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic       en_clk_i,
  input  logic [2:0] clk_mstate_i,
  input  logic       int_n_i,
  input  logic       tim_overflow_i,
  input  logic       en_tcnti_i,
  input  logic       dis_tcnti_i,
  input  logic       en_i_i,
  input  logic       dis_i_i,
  input  logic       jtf_i,
  input  logic       retr_i,
  input  logic       last_cycle_i,
  input  logic       ack_i,
  output logic       tf_o,
  output logic       int_req_o,
  output logic [7:0] int_vec_o,
  output logic       int_in_prog_o
);

  int_state_t state, state_nxt;

  logic tcnti_en, ext_en, tim_pend, int_q;
  logic src_tim;
  logic ext, tim, gone, start;

  assign ext = int_q & ext_en;
  assign tim = tim_pend;

  // Strobes of this cycle count, so the request drops one clock later.
  assign gone = src_tim ? !(tim_pend & !dis_tcnti_i)
                        : !(int_q & ext_en & !dis_i_i);

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state <= IDLE;
    end else if (en_clk_i) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if ((ext | tim) & last_cycle_i & !int_in_prog_o)
          state_nxt = REQ;
      REQ:
        if (ack_i)
          state_nxt = ISR;
        else if (gone)
          state_nxt = IDLE;
      ISR:
        if (retr_i)
          state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    int_req_o     = (state == REQ);
    int_in_prog_o = (state == ISR);
  end

  assign start = (state == IDLE) && (state_nxt == REQ);

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      tf_o      <= 1'b0;
      tcnti_en  <= 1'b0;
      ext_en    <= 1'b0;
      tim_pend  <= 1'b0;
      int_q     <= 1'b0;
      src_tim   <= 1'b0;
      int_vec_o <= EXT_VEC;
    end else if (en_clk_i) begin
      if (clk_mstate_i == MSTATE4)
        int_q <= !int_n_i;

      if (tim_overflow_i)
        tf_o <= 1'b1;
      else if (jtf_i)
        tf_o <= 1'b0;

      if (dis_tcnti_i)
        tcnti_en <= 1'b0;
      else if (en_tcnti_i)
        tcnti_en <= 1'b1;

      if (dis_i_i)
        ext_en <= 1'b0;
      else if (en_i_i)
        ext_en <= 1'b1;

      if (dis_tcnti_i)
        tim_pend <= 1'b0;
      else if (tim_overflow_i & tcnti_en)
        tim_pend <= 1'b1;
      else if (ack_i & (state == REQ) & src_tim)
        tim_pend <= 1'b0;

      if (start) begin
        src_tim   <= !ext;
        int_vec_o <= ext ? EXT_VEC : TIM_VEC;
      end
    end
  end

endmodule
